// File: rtl/counter_pkg.sv
// Shared definitions for the PWM counter control slice: mode encoding,
// shadow-transfer state encoding and default widths.
package counter_pkg;

    localparam int COUNTER_W_DEFAULT  = 16;
    localparam int PRESCALE_W_DEFAULT = 8;

    localparam logic [1:0] MODE_UP   = 2'b00;
    localparam logic [1:0] MODE_DOWN = 2'b01;
    localparam logic [1:0] MODE_HOLD = 2'b10;

    typedef enum logic {
        ST_IDLE    = 1'b0,
        ST_PENDING = 1'b1
    } shadow_state_e;

    // Modes 10 and 11 both freeze the counter, so only the upper bit matters.
    function automatic logic mode_is_hold(input logic [1:0] mode);
        return mode[1];
    endfunction

endpackage

// File: rtl/counter_prescaler.sv
// Programmable clock-enable generator: o_ce pulses once every
// (i_prescale + 1) cycles while enabled, registered one cycle after terminal count.
module counter_prescaler #(
    parameter int prescale_width = 8
) (
    input  logic                      i_clk,
    input  logic                      i_rst,
    input  logic                      i_enable,
    input  logic [prescale_width-1:0] i_prescale,
    output logic                      o_ce
);

    logic [prescale_width-1:0] r_count;
    logic                      r_ce;

    // The >= compare lets a lowered divide value wrap immediately instead of
    // running the count all the way around.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_count <= '0;
            r_ce    <= 1'b0;
        end else if (!i_enable) begin
            r_count <= '0;
            r_ce    <= 1'b0;
        end else if (r_count >= i_prescale) begin
            r_count <= '0;
            r_ce    <= 1'b1;
        end else begin
            r_count <= r_count + 1'b1;
            r_ce    <= 1'b0;
        end
    end

    assign o_ce = r_ce;

endmodule

// File: rtl/counter_shadow_ctrl.sv
// Upstream control for the up/down PWM counter: prescaled clock-enable plus
// shadowed compare/duty registers that only change at a period boundary.
module counter_shadow_ctrl
    import counter_pkg::*;
#(
    parameter int counter_width  = COUNTER_W_DEFAULT,
    parameter int prescale_width = PRESCALE_W_DEFAULT
) (
    input  logic                      i_clk,
    input  logic                      i_rst,
    input  logic                      i_enable,
    input  logic [prescale_width-1:0] i_prescale,
    input  logic [1:0]                i_counter_mode,
    input  logic [counter_width-1:0]  i_counter,
    input  logic                      i_wr_valid,
    output logic                      o_wr_ready,
    input  logic [counter_width-1:0]  i_wr_compare,
    input  logic [counter_width-1:0]  i_wr_duty,
    output logic                      o_ce,
    output logic [counter_width-1:0]  o_compare_value,
    output logic [counter_width-1:0]  o_duty,
    output logic                      o_update,
    output logic                      o_pending
);

    logic w_ce;

    counter_prescaler #(
        .prescale_width(prescale_width)
    ) u_prescaler (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_enable   (i_enable),
        .i_prescale (i_prescale),
        .o_ce       (w_ce)
    );

    shadow_state_e              r_state;
    shadow_state_e              w_state_next;
    logic [counter_width-1:0]   r_sh_compare;
    logic [counter_width-1:0]   r_sh_duty;
    logic [counter_width-1:0]   r_compare;
    logic [counter_width-1:0]   r_duty;
    logic                       r_update;

    logic w_boundary;
    logic w_idle;
    logic w_accept;
    logic w_apply;

    // Boundary coincides with the edge on which the counter itself wraps,
    // so the counter's very next comparison already sees the new values.
    always_comb begin
        w_boundary = 1'b0;
        if (w_ce) begin
            if (i_counter_mode == MODE_UP) begin
                w_boundary = (i_counter == r_compare);
            end else if (i_counter_mode == MODE_DOWN) begin
                w_boundary = (i_counter == '0);
            end
        end
    end

    assign w_idle = !i_enable || mode_is_hold(i_counter_mode);

    always_comb begin
        w_state_next = r_state;
        w_accept     = 1'b0;
        w_apply      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (i_wr_valid) begin
                    w_accept     = 1'b1;
                    w_state_next = ST_PENDING;
                end
            end
            ST_PENDING: begin
                if (w_boundary || w_idle) begin
                    w_apply      = 1'b1;
                    w_state_next = ST_IDLE;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state      <= ST_IDLE;
            r_sh_compare <= '0;
            r_sh_duty    <= '0;
            r_compare    <= '1;
            r_duty       <= '0;
            r_update     <= 1'b0;
        end else begin
            r_state  <= w_state_next;
            r_update <= w_apply;
            if (w_accept) begin
                r_sh_compare <= i_wr_compare;
                r_sh_duty    <= i_wr_duty;
            end
            if (w_apply) begin
                r_compare <= r_sh_compare;
                r_duty    <= r_sh_duty;
            end
        end
    end

    assign o_ce            = w_ce;
    assign o_compare_value = r_compare;
    assign o_duty          = r_duty;
    assign o_update        = r_update;
    assign o_pending       = (r_state == ST_PENDING);
    assign o_wr_ready      = (r_state == ST_IDLE);

endmodule

// File: tb/tb_counter_shadow_ctrl.sv
// Directed bench for counter_shadow_ctrl; the bench drives the counter
// feedback by hand, one value per clock, as the downstream counter would.
module tb_counter_shadow_ctrl;

    localparam int CW = 16;
    localparam int PW = 8;

    logic          i_clk = 1'b0;
    logic          i_rst;
    logic          i_enable;
    logic [PW-1:0] i_prescale;
    logic [1:0]    i_counter_mode;
    logic [CW-1:0] i_counter;
    logic          i_wr_valid;
    logic          o_wr_ready;
    logic [CW-1:0] i_wr_compare;
    logic [CW-1:0] i_wr_duty;
    logic          o_ce;
    logic [CW-1:0] o_compare_value;
    logic [CW-1:0] o_duty;
    logic          o_update;
    logic          o_pending;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 i_clk = ~i_clk;

    counter_shadow_ctrl #(
        .counter_width  (CW),
        .prescale_width (PW)
    ) dut (
        .i_clk           (i_clk),
        .i_rst           (i_rst),
        .i_enable        (i_enable),
        .i_prescale      (i_prescale),
        .i_counter_mode  (i_counter_mode),
        .i_counter       (i_counter),
        .i_wr_valid      (i_wr_valid),
        .o_wr_ready      (o_wr_ready),
        .i_wr_compare    (i_wr_compare),
        .i_wr_duty       (i_wr_duty),
        .o_ce            (o_ce),
        .o_compare_value (o_compare_value),
        .o_duty          (o_duty),
        .o_update        (o_update),
        .o_pending       (o_pending)
    );

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0b expected %0b", tag, obs, exp);
        end
    endtask

    task automatic chk16(input string tag, input logic [CW-1:0] obs, input logic [CW-1:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        logic ce_seen;

        i_rst          = 1'b1;
        i_enable       = 1'b0;
        i_prescale     = '0;
        i_counter_mode = 2'b00;
        i_counter      = '0;
        i_wr_valid     = 1'b0;
        i_wr_compare   = '0;
        i_wr_duty      = '0;
        tick();
        tick();
        i_rst = 1'b0;
        chk1 ("rst_ce",      o_ce, 1'b0);
        chk16("rst_compare", o_compare_value, 16'hFFFF);
        chk16("rst_duty",    o_duty, 16'h0000);
        chk1 ("rst_ready",   o_wr_ready, 1'b1);
        chk1 ("rst_pending", o_pending, 1'b0);
        chk1 ("rst_update",  o_update, 1'b0);

        // Divide by 4: terminal count reached on every 4th edge.
        i_enable   = 1'b1;
        i_prescale = 8'd3;
        for (int k = 1; k <= 8; k++) begin
            tick();
            chk1("ps3_ce", o_ce, (k % 4) == 0);
        end

        i_prescale = 8'd0;
        for (int k = 0; k < 4; k++) begin
            tick();
            chk1("ps0_ce", o_ce, 1'b1);
        end

        i_enable = 1'b0;
        tick();
        chk1("disable_ce", o_ce, 1'b0);

        i_enable   = 1'b1;
        i_prescale = 8'd200;
        ce_seen    = 1'b0;
        for (int k = 0; k < 100; k++) begin
            tick();
            ce_seen = ce_seen | o_ce;
        end
        chk1("ps200_no_ce", ce_seen, 1'b0);
        i_prescale = 8'd5;
        tick();
        chk1("lower_wrap_ce", o_ce, 1'b1);
        for (int k = 1; k <= 6; k++) begin
            tick();
            chk1("ps5_ce", o_ce, k == 6);
        end

        // Idle apply in hold mode.
        i_prescale     = 8'd0;
        i_counter_mode = 2'b10;
        i_wr_valid     = 1'b1;
        i_wr_compare   = 16'd100;
        i_wr_duty      = 16'h0033;
        tick();
        i_wr_valid = 1'b0;
        chk1 ("hold_pending", o_pending, 1'b1);
        chk1 ("hold_ready",   o_wr_ready, 1'b0);
        chk16("hold_not_yet", o_compare_value, 16'hFFFF);
        tick();
        chk16("hold_compare", o_compare_value, 16'd100);
        chk16("hold_duty",    o_duty, 16'h0033);
        chk1 ("hold_update",  o_update, 1'b1);
        tick();
        chk1 ("hold_upd_low", o_update, 1'b0);

        // Idle apply via enable low, seeding active compare 9.
        i_enable       = 1'b0;
        i_counter_mode = 2'b00;
        i_counter      = '0;
        i_wr_valid     = 1'b1;
        i_wr_compare   = 16'd9;
        i_wr_duty      = 16'd3;
        tick();
        i_wr_valid = 1'b0;
        tick();
        chk16("dis_compare", o_compare_value, 16'd9);
        chk1 ("dis_update",  o_update, 1'b1);
        i_enable = 1'b1;
        tick();

        // Up mode: write at counter 3, transfer at counter 9.
        for (int c = 0; c <= 2; c++) begin
            i_counter = CW'(c);
            tick();
        end
        i_counter    = 16'd3;
        i_wr_valid   = 1'b1;
        i_wr_compare = 16'd4;
        i_wr_duty    = 16'd2;
        tick();
        i_wr_valid = 1'b0;
        chk1("up_ready",   o_wr_ready, 1'b0);
        chk1("up_pending", o_pending, 1'b1);
        for (int c = 4; c <= 8; c++) begin
            i_counter = CW'(c);
            tick();
            chk16("up_hold_cmp", o_compare_value, 16'd9);
            chk1 ("up_no_upd",   o_update, 1'b0);
        end
        i_counter = 16'd9;
        tick();
        chk16("up_compare", o_compare_value, 16'd4);
        chk16("up_duty",    o_duty, 16'd2);
        chk1 ("up_update",  o_update, 1'b1);
        chk1 ("up_idle",    o_pending, 1'b0);
        i_counter = 16'd0;
        tick();
        chk1("up_upd_once", o_update, 1'b0);

        // Down mode: write at counter 7, transfer at counter 0.
        i_counter_mode = 2'b01;
        i_counter      = 16'd7;
        i_wr_valid     = 1'b1;
        i_wr_compare   = 16'd20;
        i_wr_duty      = 16'd10;
        tick();
        i_wr_valid = 1'b0;
        chk1("dn_pending", o_pending, 1'b1);
        for (int c = 6; c >= 1; c--) begin
            i_counter = CW'(c);
            tick();
            chk16("dn_hold_cmp", o_compare_value, 16'd4);
        end
        i_counter = 16'd0;
        tick();
        chk16("dn_compare", o_compare_value, 16'd20);
        chk16("dn_duty",    o_duty, 16'd10);
        chk1 ("dn_update",  o_update, 1'b1);

        // Back-pressure: second write held valid while the first is pending.
        i_counter_mode = 2'b00;
        i_counter      = 16'd10;
        i_wr_valid     = 1'b1;
        i_wr_compare   = 16'd30;
        i_wr_duty      = 16'd5;
        tick();
        chk1("bp_pending_a", o_pending, 1'b1);
        i_wr_compare = 16'd40;
        i_wr_duty    = 16'd7;
        for (int c = 11; c <= 19; c++) begin
            i_counter = CW'(c);
            tick();
            chk1("bp_ready_low", o_wr_ready, 1'b0);
        end
        chk16("bp_hold_cmp", o_compare_value, 16'd20);
        i_counter = 16'd20;
        tick();
        chk16("bp_cmp_a",   o_compare_value, 16'd30);
        chk16("bp_duty_a",  o_duty, 16'd5);
        chk1 ("bp_upd_a",   o_update, 1'b1);
        chk1 ("bp_ready_a", o_wr_ready, 1'b1);
        i_counter = 16'd0;
        tick();
        i_wr_valid = 1'b0;
        chk1 ("bp_pending_b", o_pending, 1'b1);
        chk16("bp_cmp_keep",  o_compare_value, 16'd30);
        chk1 ("bp_upd_low",   o_update, 1'b0);
        for (int c = 1; c <= 29; c++) begin
            i_counter = CW'(c);
            tick();
        end
        chk16("bp_wait_cmp", o_compare_value, 16'd30);
        i_counter = 16'd30;
        tick();
        chk16("bp_cmp_b",  o_compare_value, 16'd40);
        chk16("bp_duty_b", o_duty, 16'd7);
        chk1 ("bp_upd_b",  o_update, 1'b1);
        i_counter = 16'd0;
        tick();
        chk1("bp_no_dup_upd",  o_update, 1'b0);
        chk1("bp_no_dup_pend", o_pending, 1'b0);
        chk1("bp_ready_end",   o_wr_ready, 1'b1);

        // Reset while pending, with a write presented during reset.
        i_counter    = 16'd5;
        i_wr_valid   = 1'b1;
        i_wr_compare = 16'd50;
        i_wr_duty    = 16'd1;
        tick();
        i_wr_valid = 1'b0;
        chk1("rp_pending", o_pending, 1'b1);
        i_counter    = 16'd6;
        i_rst        = 1'b1;
        i_wr_valid   = 1'b1;
        i_wr_compare = 16'd77;
        tick();
        tick();
        chk1 ("rp_ce",      o_ce, 1'b0);
        chk16("rp_compare", o_compare_value, 16'hFFFF);
        chk16("rp_duty",    o_duty, 16'h0000);
        chk1 ("rp_ready",   o_wr_ready, 1'b1);
        chk1 ("rp_pending0", o_pending, 1'b0);
        chk1 ("rp_update",  o_update, 1'b0);
        i_rst      = 1'b0;
        i_wr_valid = 1'b0;
        i_counter  = 16'd7;
        tick();
        chk1 ("rp_post_upd",  o_update, 1'b0);
        chk1 ("rp_post_pend", o_pending, 1'b0);
        chk16("rp_post_cmp",  o_compare_value, 16'hFFFF);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/counter_shadow_ctrl.md
Name: counter_shadow_ctrl

Overview:
- Upstream control stage for the 16-bit up/down PWM counter.
- Generates the counter's clock-enable from a programmable prescaler.
- Holds software-written compare/duty values in shadow registers and transfers them to the counter's i_compare_value / i_duty only at a period boundary, so PWM updates are glitch-free.
- Writes arrive over a valid/ready handshake; the counter's o_counter is fed back to detect the boundary.

Parameters:
- counter_width, 16, width of counter, compare and duty values
- prescale_width, 8, width of prescaler divide value

Ports:
- i_clk  in  1  system clock, all logic on rising edge
- i_rst  in  1  synchronous reset, active-high
- i_enable  in  1  run enable for prescaler
- i_prescale  in  prescale_width  divide value N; o_ce rate = clk/(N+1)
- i_counter_mode  in  2  same encoding as counter: 00 up, 01 down, 10/11 hold
- i_counter  in  counter_width  counter's o_counter feedback
- i_wr_valid  in  1  write request
- o_wr_ready  out  1  shadow free, write accepted when valid&ready
- i_wr_compare  in  counter_width  new compare value
- i_wr_duty  in  counter_width  new duty value
- o_ce  out  1  clock-enable to counter i_ce
- o_compare_value  out  counter_width  active compare to counter
- o_duty  out  counter_width  active duty to counter
- o_update  out  1  one-cycle pulse when active values changed
- o_pending  out  1  shadow holds unapplied values

Behaviour:
- Reset is synchronous and active-high on i_rst. Next edge gives:
  - prescale count = 0, o_ce = 0
  - o_compare_value = all ones, o_duty = 0
  - shadow registers = 0, state IDLE
  - o_update = 0, o_pending = 0, o_wr_ready = 1
- A write during i_rst is ignored.
- Prescaler:
  - Count register runs 0..i_prescale.
  - When i_enable=1 and count >= i_prescale: count <= 0 and o_ce <= 1. Otherwise count <= count+1 and o_ce <= 0.
  - o_ce is registered: it appears one cycle after the terminal count.
  - i_prescale=0 gives o_ce high every cycle while enabled.
  - Lowering i_prescale below the current count causes a wrap on the next cycle (the >= compare). No stuck state.
  - i_enable=0: count <= 0, o_ce <= 0 on the next edge.
- Boundary, evaluated each cycle with the registered o_ce:
  - Up mode (00): o_ce=1 and i_counter == o_compare_value.
  - Down mode (01): o_ce=1 and i_counter == 0.
  - The transfer happens on the same edge at which the counter wraps. The counter's next comparison therefore uses the new values.
- Idle condition: i_enable=0 or mode 10/11.
- State machine (o_pending = state PENDING; o_wr_ready = state IDLE, combinational from state):
  - IDLE: on i_wr_valid&o_wr_ready, latch i_wr_compare/i_wr_duty into the shadow and go to PENDING.
  - PENDING: on boundary or idle condition, copy shadow to active, pulse o_update for 1 cycle, go to IDLE.
- No same-cycle bypass. A write accepted in a boundary cycle waits for the next boundary, or for the idle condition.
- Mode changed while PENDING: boundary detection follows the current i_counter_mode each cycle.
- Reset mid-PENDING: shadow contents are discarded and no o_update pulse is produced.
- Width rules:
  - All compares are unsigned and counter_width wide.
  - Prescale compare is prescale_width wide.
  - No arithmetic overflow except the prescale count increment, which cannot exceed i_prescale by construction except via the lowering case above.

Decomposition:
- Shared package (counter_pkg):
  - counter mode constants MODE_UP=2'b00, MODE_DOWN=2'b01, MODE_HOLD=2'b10
  - state encoding IDLE/PENDING
  - default counter_width
- One natural sub-module: counter_prescaler, which holds the count register and registered o_ce, with i_enable/i_prescale inputs. The shadow FSM stays in the top.

Test Plan:
- Reset: assert i_rst 2 cycles mid-operation -> o_ce=0, o_compare_value=16'hFFFF, o_duty=0, o_wr_ready=1, o_pending=0, o_update=0.
- Prescale: i_enable=1, i_prescale=3 -> o_ce high exactly 1 of every 4 cycles. With i_prescale=0, o_ce is continuously high. Lower i_prescale from 200 to 5 at count 100 -> wrap next cycle, then period 6.
- Up-mode glitch-free update:
  - Setup: mode 00, prescale 0, active compare 9, counter model running.
  - Stimulus: write compare=4, duty=2 when i_counter=3.
  - Response: o_wr_ready drops next cycle and o_pending=1. Active values are unchanged until the cycle o_ce=1 and i_counter=9. On that edge both change and o_update pulses once.
- Down-mode update: mode 01, write compare=20, duty=10 at i_counter=7 -> transfer occurs on the o_ce cycle with i_counter=0, and not before.
- Idle apply and back-pressure:
  - Idle apply: mode 10, write compare=100 -> active=100 two cycles after acceptance, with an o_update pulse.
  - Back-pressure: in mode 00, hold i_wr_valid high with a second value while PENDING -> it is not accepted until o_wr_ready returns. It is then applied at the following boundary. No values are lost or duplicated.
- Reset while PENDING: write compare=50, assert i_rst before the boundary -> o_compare_value=16'hFFFF, no o_update, o_pending=0.
